// File: rtl/tl_pkg.sv
// Shared light codes, phase encoding and default widths for the intersection scheduler.
package tl_pkg;

  localparam int TW_DEF = 11;
  localparam int CW_DEF = 9;

  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_YEL = 2'b01;
  localparam logic [1:0] LIGHT_GRN = 2'b11;

  typedef enum logic [3:0] {
    INIT,
    A_GRN,
    A_YEL,
    CLR_A,
    B_GRN,
    B_YEL,
    CLR_B,
    WALK,
    CLR_W
  } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: loads max(len,1)-1 on i_load, counts to zero and holds there.
// o_done is combinational from the count, so it reads 1 on the last cycle of a phase.
module phase_timer #(
  parameter int TW = 11
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_len,
  output logic          o_done
);

  localparam logic [TW-1:0] ONE = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= (i_len == '0) ? '0 : i_len - ONE;
    end else if (r_count != '0) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection phase sequencer with on-demand side street and walk phase.
// Outputs are registered from the next-state decode, so they line up with the current phase.
import tl_pkg::*;

module intersection_scheduler #(
  parameter int TW = TW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [TW-1:0] i_a_green_len,
  input  logic [TW-1:0] i_a_yel_len,
  input  logic [TW-1:0] i_b_green_len,
  input  logic [TW-1:0] i_b_yel_len,
  input  logic [TW-1:0] i_clear_len,
  input  logic [TW-1:0] i_walk_len,
  input  logic          i_b_demand,
  input  logic          i_walk_button,
  output logic [1:0]    o_light_a,
  output logic [1:0]    o_light_b,
  output logic          o_walk_light,
  output logic          o_walk_pending,
  output logic          o_phase_start,
  output logic [CW-1:0] o_cycle_count
);

  localparam logic [CW-1:0] CC_ONE = {{(CW-1){1'b0}}, 1'b1};

  phase_t        r_state;
  phase_t        w_next;
  logic          w_done;
  logic [TW-1:0] w_len;
  logic [1:0]    w_light_a;
  logic [1:0]    w_light_b;
  logic          w_b_seen_nxt;
  logic          w_wp_nxt;
  logic          r_b_seen;
  logic          r_walk_pending;
  logic [1:0]    r_light_a;
  logic [1:0]    r_light_b;
  logic          r_walk_light;
  logic          r_phase_start;
  logic [CW-1:0] r_cycle_count;

  phase_timer #(.TW(TW)) u_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_done),
    .i_len   (w_len),
    .o_done  (w_done)
  );

  always_comb begin
    w_next = r_state;
    if (w_done) begin
      case (r_state)
        INIT:    w_next = A_GRN;
        A_GRN:   w_next = A_YEL;
        A_YEL:   w_next = CLR_A;
        CLR_A:   w_next = r_walk_pending ? WALK : (r_b_seen ? B_GRN : A_GRN);
        B_GRN:   w_next = B_YEL;
        B_YEL:   w_next = CLR_B;
        CLR_B:   w_next = r_walk_pending ? WALK : A_GRN;
        WALK:    w_next = CLR_W;
        CLR_W:   w_next = A_GRN;
        default: w_next = INIT;
      endcase
    end
  end

  // Length and light decode follow the phase being entered, so the timer and
  // output registers pick up the new phase on the same edge as the state.
  always_comb begin
    w_len     = '0;
    w_light_a = LIGHT_RED;
    w_light_b = LIGHT_RED;
    case (w_next)
      A_GRN:               begin w_len = i_a_green_len; w_light_a = LIGHT_GRN; end
      A_YEL:               begin w_len = i_a_yel_len;   w_light_a = LIGHT_YEL; end
      B_GRN:               begin w_len = i_b_green_len; w_light_b = LIGHT_GRN; end
      B_YEL:               begin w_len = i_b_yel_len;   w_light_b = LIGHT_YEL; end
      CLR_A, CLR_B, CLR_W: w_len = i_clear_len;
      WALK:                w_len = i_walk_len;
      default:             w_len = '0;
    endcase
  end

  always_comb begin
    w_b_seen_nxt = r_b_seen | (i_b_demand && (r_state != B_GRN) && (r_state != B_YEL));
    if (w_done && (w_next == B_GRN)) w_b_seen_nxt = 1'b0;
    w_wp_nxt = r_walk_pending | (i_walk_button && (r_state != WALK));
    if (w_done && (w_next == WALK)) w_wp_nxt = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= INIT;
      r_b_seen       <= 1'b0;
      r_walk_pending <= 1'b0;
      r_light_a      <= LIGHT_RED;
      r_light_b      <= LIGHT_RED;
      r_walk_light   <= 1'b0;
      r_phase_start  <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      r_state        <= w_next;
      r_b_seen       <= w_b_seen_nxt;
      r_walk_pending <= w_wp_nxt;
      r_light_a      <= w_light_a;
      r_light_b      <= w_light_b;
      r_walk_light   <= (w_next == WALK);
      r_phase_start  <= w_done;
      if (w_done && (w_next == A_GRN)) r_cycle_count <= r_cycle_count + CC_ONE;
    end
  end

  assign o_light_a      = r_light_a;
  assign o_light_b      = r_light_b;
  assign o_walk_light   = r_walk_light;
  assign o_walk_pending = r_walk_pending;
  assign o_phase_start  = r_phase_start;
  assign o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed, table-driven bench for intersection_scheduler.
module tb_intersection_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] a_g, a_y, b_g, b_y, clr, wlk;
  logic        bd, wb;
  logic [1:0]  la, lb;
  logic        wl, wp, ps;
  logic [8:0]  cc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       bd;
    logic       wb;
    logic [1:0] la;
    logic [1:0] lb;
    logic       wl;
    logic       wp;
    logic       ps;
    logic [8:0] cc;
  } vec_t;

  vec_t q[$];

  always #5 clk = ~clk;

  intersection_scheduler dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_a_green_len  (a_g),
    .i_a_yel_len    (a_y),
    .i_b_green_len  (b_g),
    .i_b_yel_len    (b_y),
    .i_clear_len    (clr),
    .i_walk_len     (wlk),
    .i_b_demand     (bd),
    .i_walk_button  (wb),
    .o_light_a      (la),
    .o_light_b      (lb),
    .o_walk_light   (wl),
    .o_walk_pending (wp),
    .o_phase_start  (ps),
    .o_cycle_count  (cc)
  );

  always @(negedge clk) begin
    checks = checks + 1;
    if (la != 2'b00 && lb != 2'b00) begin
      errors = errors + 1;
      $display("FAIL both_lights_non_red: light_a=%b light_b=%b required one red", la, lb);
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s row %0d: actual %0h required %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input logic [10:0] l, input logic [10:0] w);
    a_g = l; a_y = l; b_g = l; b_y = l; clr = l; wlk = w;
  endtask

  task automatic do_reset();
    rst = 1'b1; bd = 1'b0; wb = 1'b0;
    step();
    step();
    chk("rst_light_a", -1, {30'd0, la}, 32'd0);
    chk("rst_light_b", -1, {30'd0, lb}, 32'd0);
    chk("rst_walk_light", -1, {31'd0, wl}, 32'd0);
    chk("rst_walk_pending", -1, {31'd0, wp}, 32'd0);
    chk("rst_phase_start", -1, {31'd0, ps}, 32'd0);
    chk("rst_cycle_count", -1, {23'd0, cc}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic seg(input logic [1:0] sla, input logic [1:0] slb, input logic swl,
                     input logic swp, input int scc, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.bd = 1'b0; v.wb = 1'b0;
      v.la = sla; v.lb = slb; v.wl = swl; v.wp = swp;
      v.ps = (i == 0);
      v.cc = scc[8:0];
      q.push_back(v);
    end
  endtask

  task automatic run_table(input string tag);
    for (int r = 0; r < q.size(); r++) begin
      bd = q[r].bd;
      wb = q[r].wb;
      step();
      chk({tag, "_light_a"}, r, {30'd0, la}, {30'd0, q[r].la});
      chk({tag, "_light_b"}, r, {30'd0, lb}, {30'd0, q[r].lb});
      chk({tag, "_walk_light"}, r, {31'd0, wl}, {31'd0, q[r].wl});
      chk({tag, "_walk_pending"}, r, {31'd0, wp}, {31'd0, q[r].wp});
      chk({tag, "_phase_start"}, r, {31'd0, ps}, {31'd0, q[r].ps});
      chk({tag, "_cycle_count"}, r, {23'd0, cc}, {23'd0, q[r].cc});
    end
    bd = 1'b0;
    wb = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; bd = 1'b0; wb = 1'b0;
    set_len(11'd3, 11'd5);

    // Tests 1-3: plain cycle, B on demand, walk beats B, held button, B next pass.
    do_reset();
    seg(2'b11, 2'b00, 0, 0, 1, 3);  // 0-2   A_GRN
    seg(2'b01, 2'b00, 0, 0, 1, 3);  // 3-5   A_YEL
    seg(2'b00, 2'b00, 0, 0, 1, 3);  // 6-8   CLR_A
    seg(2'b11, 2'b00, 0, 0, 2, 3);  // 9-11  A_GRN return
    seg(2'b01, 2'b00, 0, 0, 2, 3);  // 12-14
    seg(2'b00, 2'b00, 0, 0, 2, 3);  // 15-17
    seg(2'b00, 2'b11, 0, 0, 2, 3);  // 18-20 B_GRN
    seg(2'b00, 2'b01, 0, 0, 2, 3);  // 21-23 B_YEL
    seg(2'b00, 2'b00, 0, 0, 2, 3);  // 24-26 CLR_B
    seg(2'b11, 2'b00, 0, 0, 3, 3);  // 27-29
    seg(2'b01, 2'b00, 0, 0, 3, 3);  // 30-32
    seg(2'b00, 2'b00, 0, 1, 3, 3);  // 33-35 CLR_A, walk pending
    seg(2'b00, 2'b00, 1, 0, 3, 5);  // 36-40 WALK
    seg(2'b00, 2'b00, 0, 0, 3, 3);  // 41-43 CLR_W
    seg(2'b11, 2'b00, 0, 0, 4, 3);  // 44-46
    seg(2'b01, 2'b00, 0, 0, 4, 3);  // 47-49
    seg(2'b00, 2'b00, 0, 0, 4, 3);  // 50-52
    seg(2'b00, 2'b11, 0, 0, 4, 3);  // 53-55 B served on next pass
    seg(2'b00, 2'b01, 0, 0, 4, 3);  // 56-58
    seg(2'b00, 2'b00, 0, 0, 4, 3);  // 59-61
    seg(2'b11, 2'b00, 0, 0, 5, 3);  // 62-64
    seg(2'b01, 2'b00, 0, 0, 5, 3);  // 65-67
    seg(2'b00, 2'b00, 0, 0, 5, 3);  // 68-70 no B demand left
    seg(2'b11, 2'b00, 0, 0, 6, 3);  // 71-73
    q[10].bd = 1'b1;
    q[31].bd = 1'b1;
    q[31].wb = 1'b1;
    q[31].wp = 1'b1;
    q[32].wp = 1'b1;
    for (int r = 36; r <= 41; r++) q[r].wb = 1'b1;
    run_table("seq");

    // Test 4: all lengths zero, every phase one cycle.
    q.delete();
    set_len(11'd0, 11'd0);
    do_reset();
    seg(2'b11, 2'b00, 0, 0, 1, 1);
    seg(2'b01, 2'b00, 0, 0, 1, 1);
    seg(2'b00, 2'b00, 0, 0, 1, 1);
    seg(2'b00, 2'b11, 0, 0, 1, 1);
    seg(2'b00, 2'b01, 0, 0, 1, 1);
    seg(2'b00, 2'b00, 0, 0, 1, 1);
    seg(2'b11, 2'b00, 0, 0, 2, 1);
    seg(2'b01, 2'b00, 0, 0, 2, 1);
    seg(2'b00, 2'b00, 0, 0, 2, 1);
    seg(2'b11, 2'b00, 0, 0, 3, 1);
    q[1].bd = 1'b1;
    run_table("zero");

    // Test 5: reset mid-B_GRN with walk pending.
    set_len(11'd3, 11'd5);
    do_reset();
    bd = 1'b1;
    step();
    bd = 1'b0;
    for (int i = 0; i < 8; i++) step();
    wb = 1'b1;
    step();
    wb = 1'b0;
    chk("mid_b_light_b", 0, {30'd0, lb}, 32'd3);
    chk("mid_b_walk_pending", 0, {31'd0, wp}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_light_a", 0, {30'd0, la}, 32'd0);
    chk("rst_mid_light_b", 0, {30'd0, lb}, 32'd0);
    chk("rst_mid_walk_pending", 0, {31'd0, wp}, 32'd0);
    chk("rst_mid_cycle_count", 0, {23'd0, cc}, 32'd0);
    chk("rst_mid_phase_start", 0, {31'd0, ps}, 32'd0);
    rst = 1'b0;
    step();
    chk("after_rst_light_a", 0, {30'd0, la}, 32'd3);
    chk("after_rst_phase_start", 0, {31'd0, ps}, 32'd1);
    chk("after_rst_cycle_count", 0, {23'd0, cc}, 32'd1);

    // Test 6: cycle_count wrap 511 -> 0.
    set_len(11'd0, 11'd0);
    do_reset();
    n = 0;
    while (cc != 9'd511 && n < 2000) begin
      step();
      n++;
    end
    chk("wrap_reach_511", 0, {23'd0, cc}, 32'd511);
    chk("wrap_511_light_a", 0, {30'd0, la}, 32'd3);
    step();
    chk("wrap_hold_cc", 1, {23'd0, cc}, 32'd511);
    step();
    chk("wrap_hold_cc", 2, {23'd0, cc}, 32'd511);
    step();
    chk("wrap_cc_zero", 3, {23'd0, cc}, 32'd0);
    chk("wrap_light_a", 3, {30'd0, la}, 32'd3);
    chk("wrap_phase_start", 3, {31'd0, ps}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
